// File: rtl/rtc_time_core_if.sv
// rtl/rtc_time_core_if.sv - control inputs and BCD time outputs of the timekeeping core
interface rtc_time_core_if;
  logic       clk_1kHz;
  logic       set_en;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] hour_t;
  logic [3:0] hour_u;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic       sec_pulse;

  modport master (
    output clk_1kHz, set_en, inc_min, inc_hour,
    input  hour_t, hour_u, min_t, min_u, sec_t, sec_u, sec_pulse
  );

  modport slave (
    input  clk_1kHz, set_en, inc_min, inc_hour,
    output hour_t, hour_u, min_t, min_u, sec_t, sec_u, sec_pulse
  );
endinterface

// File: rtl/rtc_time_core.sv
// rtl/rtc_time_core.sv - millisecond tick counter and 24-hour BCD HH:MM:SS with set mode
module rtc_time_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TICK_W        = 10
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  rtc_time_core_if.slave   bus
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);

  logic              clk_1k_d;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic              sec_pulse;

  logic [3:0] sec_u_inc, sec_t_inc, min_u_inc, min_t_inc, hour_u_inc, hour_t_inc;
  logic       sec_carry, min_carry;

  // The divider output is data here: either edge of it is one millisecond tick.
  assign tick = bus.clk_1kHz ^ clk_1k_d;

  // Incremented value of each field; seconds and minutes wrap at 59, hours at 23.
  always_comb begin
    sec_carry  = (sec_t == 4'd5) && (sec_u == 4'd9);
    sec_u_inc  = (sec_u == 4'd9) ? 4'd0 : sec_u + 4'd1;
    sec_t_inc  = (sec_u != 4'd9) ? sec_t : (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
    min_carry  = (min_t == 4'd5) && (min_u == 4'd9);
    min_u_inc  = (min_u == 4'd9) ? 4'd0 : min_u + 4'd1;
    min_t_inc  = (min_u != 4'd9) ? min_t : (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
    hour_u_inc = hour_u + 4'd1;
    hour_t_inc = hour_t;
    if ((hour_t == 4'd2) && (hour_u == 4'd3)) begin
      hour_u_inc = 4'd0;
      hour_t_inc = 4'd0;
    end else if (hour_u == 4'd9) begin
      hour_u_inc = 4'd0;
      hour_t_inc = hour_t + 4'd1;
    end
  end

  // Tick capture, millisecond count, set-mode adjustment and the full carry chain.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      clk_1k_d  <= 1'b0;
      tick_cnt  <= '0;
      hour_t    <= 4'd0;
      hour_u    <= 4'd0;
      min_t     <= 4'd0;
      min_u     <= 4'd0;
      sec_t     <= 4'd0;
      sec_u     <= 4'd0;
      sec_pulse <= 1'b0;
    end else begin
      clk_1k_d  <= bus.clk_1kHz;
      sec_pulse <= 1'b0;
      if (bus.set_en) begin
        // Set mode owns the time; a coincident tick is dropped on purpose.
        tick_cnt <= '0;
        sec_t    <= 4'd0;
        sec_u    <= 4'd0;
        if (bus.inc_min) begin
          min_u <= min_u_inc;
          min_t <= min_t_inc;
        end
        if (bus.inc_hour) begin
          hour_u <= hour_u_inc;
          hour_t <= hour_t_inc;
        end
      end else if (tick) begin
        if (tick_cnt < TICK_MAX) begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end else begin
          tick_cnt  <= '0;
          sec_pulse <= 1'b1;
          sec_u     <= sec_u_inc;
          sec_t     <= sec_t_inc;
          if (sec_carry) begin
            min_u <= min_u_inc;
            min_t <= min_t_inc;
            if (min_carry) begin
              hour_u <= hour_u_inc;
              hour_t <= hour_t_inc;
            end
          end
        end
      end
    end
  end

  assign bus.hour_t    = hour_t;
  assign bus.hour_u    = hour_u;
  assign bus.min_t     = min_t;
  assign bus.min_u     = min_u;
  assign bus.sec_t     = sec_t;
  assign bus.sec_u     = sec_u;
  assign bus.sec_pulse = sec_pulse;

endmodule

// File: tb/tb_rtc_time_core.sv
// tb/tb_rtc_time_core.sv - scoreboard bench for rtc_time_core with a 4-tick second
module tb_rtc_time_core;
  localparam int TPS = 4;

  logic clk_50MHz = 1'b0;
  logic rst = 1'b1;

  rtc_time_core_if bus ();

  rtc_time_core #(.TICKS_PER_SEC(TPS), .TICK_W(3)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  // Reference time, kept as plain integers.
  int   m_h = 0, m_m = 0, m_s = 0, m_ticks = 0;
  logic m_k_d = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] pre_digits;
  logic prev_pulse = 1'b0;

  function automatic logic [23:0] bcd(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] digits();
    return {bus.hour_t, bus.hour_u, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  // Drive one cycle of inputs, capture the outputs just before the edge, update the model.
  task automatic clock_step(input logic k, input logic s, input logic im, input logic ih);
    bus.clk_1kHz = k;
    bus.set_en   = s;
    bus.inc_min  = im;
    bus.inc_hour = ih;
    @(negedge clk_50MHz);
    pre_digits = digits();
    if (s) begin
      m_s = 0;
      m_ticks = 0;
      if (im) m_m = (m_m + 1) % 60;
      if (ih) m_h = (m_h + 1) % 24;
    end else if (k != m_k_d) begin
      if (m_ticks < TPS - 1) begin
        m_ticks++;
      end else begin
        m_ticks = 0;
        m_s++;
        if (m_s == 60) begin
          m_s = 0;
          m_m++;
          if (m_m == 60) begin
            m_m = 0;
            m_h = (m_h + 1) % 24;
          end
        end
        exp_q.push_back(bcd(m_h, m_m, m_s));
      end
    end
    m_k_d = k;
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic run_secs(input int n, input int gap);
    repeat (n * TPS) begin
      clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
      repeat (gap - 1) clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    end
    clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int m);
    clock_step(m_k_d, 1'b1, 1'b0, 1'b0);
    while (m_h != h) clock_step(m_k_d, 1'b1, 1'b0, 1'b1);
    while (m_m != m) clock_step(m_k_d, 1'b1, 1'b1, 1'b0);
  endtask

  // Scoreboard: every sec_pulse pops the time the model expects after that rollover.
  always @(negedge clk_50MHz) begin
    logic [23:0] want;
    logic [23:0] got;
    if (!rst) begin
      if (bus.sec_pulse) begin
        pulse_cnt++;
        got = digits();
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sec_pulse_unexpected got=1 want=0 time=%0t", $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) $display("FAIL pulse_time got=%h want=%h", got, want);
          else pass_cnt++;
        end
        total_cnt++;
        if (prev_pulse) $display("FAIL sec_pulse_double got=11 want=10");
        else pass_cnt++;
        total_cnt++;
        if (got[23:20] > 4'd2 || got[19:16] > 4'd9 || got[15:12] > 4'd5 ||
            got[11:8] > 4'd9 || got[7:4] > 4'd5 || got[3:0] > 4'd9)
          $display("FAIL digit_range got=%h want=in_range", got);
        else pass_cnt++;
      end
      prev_pulse = bus.sec_pulse;
    end
  end

  task automatic check_queue_empty(input string name);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.clk_1kHz = 1'b0;
    bus.set_en   = 1'b0;
    bus.inc_min  = 1'b0;
    bus.inc_hour = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_50MHz);
    #1;
    total_cnt++;
    if (digits() !== 24'h000000) $display("FAIL reset_digits got=%h want=000000", digits());
    else pass_cnt++;
    total_cnt++;
    if (bus.sec_pulse !== 1'b0) $display("FAIL reset_pulse got=%b want=0", bus.sec_pulse);
    else pass_cnt++;
    #2 rst = 1'b0;
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic test_tick_count();
    logic [23:0] old;
    for (int e = 1; e <= 2 * TPS; e++) begin
      old = bcd(m_h, m_m, m_s);
      clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
      if (e % TPS == 0) begin
        total_cnt++;
        if (pre_digits !== old) $display("FAIL tick_latency got=%h want=%h", pre_digits, old);
        else pass_cnt++;
        total_cnt++;
        if (bus.sec_u !== 4'(e / TPS)) $display("FAIL tick_sec_u got=%0d want=%0d", bus.sec_u, e / TPS);
        else pass_cnt++;
        total_cnt++;
        if (bus.sec_pulse !== 1'b1) $display("FAIL tick_pulse_high got=%b want=1", bus.sec_pulse);
        else pass_cnt++;
        clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.sec_pulse !== 1'b0) $display("FAIL tick_pulse_width got=%b want=0", bus.sec_pulse);
        else pass_cnt++;
        repeat (8) clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
      end else begin
        total_cnt++;
        if (digits() !== old) $display("FAIL tick_hold got=%h want=%h", digits(), old);
        else pass_cnt++;
        repeat (9) clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
      end
    end
    check_queue_empty("tick");
  endtask

  task automatic test_rollover();
    set_time(23, 59);
    run_secs(59, 2);
    total_cnt++;
    if (digits() !== 24'h235959) $display("FAIL rollover_pre got=%h want=235959", digits());
    else pass_cnt++;
    repeat (TPS - 1) begin
      clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
      clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    end
    clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (pre_digits !== 24'h235959) $display("FAIL rollover_before_edge got=%h want=235959", pre_digits);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 24'h000000) $display("FAIL rollover_wrap got=%h want=000000", digits());
    else pass_cnt++;
    total_cnt++;
    if (bus.sec_pulse !== 1'b1) $display("FAIL rollover_pulse got=%b want=1", bus.sec_pulse);
    else pass_cnt++;
    clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    check_queue_empty("rollover");
  endtask

  task automatic test_carries();
    int          start_h[4] = '{0, 0, 0, 9};
    int          start_m[4] = '{0, 9, 59, 59};
    logic [23:0] after[4]   = '{24'h000100, 24'h001000, 24'h010000, 24'h100000};
    for (int i = 0; i < 4; i++) begin
      set_time(start_h[i], start_m[i]);
      run_secs(59, 2);
      total_cnt++;
      if (digits() !== bcd(start_h[i], start_m[i], 59))
        $display("FAIL carry_pre_%0d got=%h want=%h", i, digits(), bcd(start_h[i], start_m[i], 59));
      else pass_cnt++;
      run_secs(1, 2);
      total_cnt++;
      if (digits() !== after[i]) $display("FAIL carry_post_%0d got=%h want=%h", i, digits(), after[i]);
      else pass_cnt++;
    end
    check_queue_empty("carry");
  endtask

  task automatic test_set_mode();
    int p0;
    set_time(5, 17);
    run_secs(42, 2);
    total_cnt++;
    if (digits() !== 24'h051742) $display("FAIL set_start got=%h want=051742", digits());
    else pass_cnt++;
    clock_step(m_k_d, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (digits() !== 24'h051700) $display("FAIL set_sec_clear got=%h want=051700", digits());
    else pass_cnt++;
    repeat (43) clock_step(m_k_d, 1'b1, 1'b1, 1'b0);
    clock_step(m_k_d, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (digits() !== 24'h050000) $display("FAIL set_min_wrap got=%h want=050000", digits());
    else pass_cnt++;
    p0 = pulse_cnt;
    repeat (3 * TPS) begin
      clock_step(~m_k_d, 1'b1, 1'b0, 1'b0);
      clock_step(m_k_d, 1'b1, 1'b0, 1'b0);
    end
    total_cnt++;
    if (digits() !== 24'h050000 || pulse_cnt != p0)
      $display("FAIL set_ticks_ignored got=%h/%0d want=050000/%0d", digits(), pulse_cnt, p0);
    else pass_cnt++;
    set_time(23, 59);
    total_cnt++;
    if (digits() !== 24'h235900) $display("FAIL set_preset got=%h want=235900", digits());
    else pass_cnt++;
    clock_step(m_k_d, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (digits() !== 24'h000000) $display("FAIL set_both_inc got=%h want=000000", digits());
    else pass_cnt++;
  endtask

  task automatic test_release_ignore();
    int p0;
    clock_step(m_k_d, 1'b0, 1'b1, 1'b1);
    clock_step(m_k_d, 1'b0, 1'b1, 1'b0);
    clock_step(m_k_d, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (digits() !== 24'h000000) $display("FAIL run_inc_ignored got=%h want=000000", digits());
    else pass_cnt++;
    clock_step(m_k_d, 1'b1, 1'b0, 1'b0);
    clock_step(~m_k_d, 1'b1, 1'b0, 1'b0);
    p0 = pulse_cnt;
    repeat (TPS - 1) begin
      clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
      clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    end
    total_cnt++;
    if (pulse_cnt != p0 || digits() !== 24'h000000)
      $display("FAIL release_early got=%0d/%h want=%0d/000000", pulse_cnt, digits(), p0);
    else pass_cnt++;
    clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bus.sec_pulse !== 1'b1 || digits() !== 24'h000001)
      $display("FAIL release_first_pulse got=%b/%h want=1/000001", bus.sec_pulse, digits());
    else pass_cnt++;
    clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    check_queue_empty("release");
  endtask

  task automatic test_reset_mid();
    set_time(12, 34);
    run_secs(55, 2);
    repeat (TPS - 1) begin
      clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
      clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    end
    clock_step(~m_k_d, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (digits() !== 24'h123456 || bus.sec_pulse !== 1'b1)
      $display("FAIL midreset_pre got=%h/%b want=123456/1", digits(), bus.sec_pulse);
    else pass_cnt++;
    #2 rst = 1'b1;
    bus.clk_1kHz = 1'b0;
    #1;
    total_cnt++;
    if (digits() !== 24'h000000) $display("FAIL midreset_async_digits got=%h want=000000", digits());
    else pass_cnt++;
    total_cnt++;
    if (bus.sec_pulse !== 1'b0) $display("FAIL midreset_async_pulse got=%b want=0", bus.sec_pulse);
    else pass_cnt++;
    exp_q.delete();
    m_h = 0; m_m = 0; m_s = 0; m_ticks = 0; m_k_d = 1'b0;
    prev_pulse = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    #3 rst = 1'b0;
    @(posedge clk_50MHz);
    #1;
    clock_step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (dut.tick_cnt !== 3'd1 || digits() !== 24'h000000)
      $display("FAIL midreset_first_tick got=%0d/%h want=1/000000", dut.tick_cnt, digits());
    else pass_cnt++;
    clock_step(m_k_d, 1'b0, 1'b0, 1'b0);
    run_secs(1, 2);
    check_queue_empty("midreset");
  endtask

  initial begin
    test_reset();
    test_tick_count();
    test_rollover();
    test_carries();
    test_set_mode();
    test_release_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_time_core.md
Name: rtc_time_core

Overview:
- Timekeeping core of the digital clock, directly downstream of the 50 MHz→1 kHz divider.
- Consumes the divider's clk_1kHz square wave as data, not as a clock. It detects transitions in the clk_50MHz domain, counts milliseconds, and maintains 24-hour BCD time HH:MM:SS.
- Provides a set mode for manual minute/hour adjustment.
- Feeds the seven-segment decode stage.

Parameters:
- TICKS_PER_SEC, 1000, number of clk_1kHz transitions (either edge) per second.
- TICK_W, 10, width of the tick counter; must satisfy 2^TICK_W > TICKS_PER_SEC-1.

Ports:
- clk_50MHz  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_1kHz  input  1  divider output, synchronous to clk_50MHz; toggles once per 1 ms.
- set_en  input  1  level; high = set mode.
- inc_min  input  1  one-cycle pulse (already debounced); minutes +1 in set mode.
- inc_hour  input  1  one-cycle pulse (already debounced); hours +1 in set mode.
- hour_t  output  4  hours tens BCD, 0..2.
- hour_u  output  4  hours units BCD, 0..9.
- min_t  output  4  minutes tens BCD, 0..5.
- min_u  output  4  minutes units BCD, 0..9.
- sec_t  output  4  seconds tens BCD, 0..5.
- sec_u  output  4  seconds units BCD, 0..9.
- sec_pulse  output  1  one-cycle strobe on each counted second rollover.

Behaviour:
- Reset (async, rst=1): all BCD outputs 0 (00:00:00); sec_pulse=0; tick_cnt=0; clk_1k_d=0. Outputs are held while rst=1.
- Tick detect: clk_1k_d registers clk_1kHz every cycle.
  - tick = clk_1kHz XOR clk_1k_d, combinational. Both edges count, so one tick per ms.
  - Because clk_1k_d resets to 0, a high clk_1kHz on the first post-reset cycle counts as a tick. This is the defined behaviour.
- Run mode (set_en=0), on a cycle with tick=1:
  - If tick_cnt < TICKS_PER_SEC-1: tick_cnt+1.
  - Else: tick_cnt←0, advance seconds, sec_pulse=1 for the next cycle only.
  - The digit update lands on the same clk edge that captures the edge in clk_1k_d. Latency is 1 clock from the clk_1kHz change to the visible output change.
- Advance chain, all in one cycle:
  - sec_u 9→0 carries into sec_t; sec_t:sec_u 59→00 carries into minutes.
  - min 59→00 carries into hours.
  - hours: units wrap 9→0 with tens+1; 23→00.
  - 23:59:59 → 00:00:00 in a single cycle.
  - No digit ever holds a non-BCD or out-of-range value.
- Set mode (set_en=1):
  - tick_cnt forced 0; sec_t/sec_u forced 0 on the first set-mode cycle and held; ticks ignored; sec_pulse=0.
  - inc_min=1: minutes +1 mod 60, with no carry into hours.
  - inc_hour=1: hours +1 mod 24.
  - inc_min and inc_hour in the same cycle: both apply independently.
  - inc_min and inc_hour are ignored when set_en=0.
- Leaving set mode (set_en 1→0): counting resumes from tick_cnt=0, sec=00. The first sec_pulse comes after exactly TICKS_PER_SEC ticks.
- A tick and set_en=1 in the same cycle: set mode wins, so the tick is discarded.
- sec_pulse is registered and never high for two consecutive cycles. This holds because the spacing between ticks is ≥2 clocks by construction.
- Mid-operation reset: time returns to 00:00:00 asynchronously, with no partial-update artefacts after release.

Test Plan:
- Reset: assert rst mid-count at 12:34:56 → all digits 0 and sec_pulse=0 immediately, without waiting for a clock edge; after release, the first tick gives tick_cnt=1 and time stays 00:00:00.
- Tick counting (TICKS_PER_SEC=4): toggle clk_1kHz every 10 clocks → sec_u increments every 40 clocks; sec_pulse is high exactly 1 cycle, 1 clock after the 4th edge; rising and falling edges both count.
- Full rollover: preset 23:59:58 via set mode; release set_en (sec becomes 00, so set 23:59 and run 59 s) → 23:59:59→00:00:00 in one cycle, all six digits change together, and one sec_pulse is produced.
- Carry boundaries: cross 00:00:59→00:01:00, 00:09:59→00:10:00, 00:59:59→01:00:00, 09:59:59→10:00:00 → correct BCD at every step, with no value above 9 (or above 5 for tens).
- Set mode: set_en=1 at 05:17:42 → seconds 00; pulse inc_min ×43 → minutes wrap 59→00 and hours stay 05; inc_min and inc_hour in the same cycle at 23:59 → 00:00; ticks during set mode leave the time unchanged.
- Release and ignore: inc_min and inc_hour with set_en=0 → no change; set_en 1→0 → first sec_pulse after exactly TICKS_PER_SEC edges; tick coinciding with set_en=1 → discarded.
